// File: rtl/diff_sched_pkg.sv
// Shared helpers for the time-shared first-difference scheduler: channel-index
// width derivation, channel-count limits and the widened subtract with optional clamp.
package diff_sched_pkg;

   localparam int NCH_MIN = 2;
   localparam int NCH_MAX = 16;
   localparam int SUB_W   = 64;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int ch_width(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

   // Operands arrive sign-extended from w bits, so the true difference always fits in w+1 bits.
   function automatic logic signed [SUB_W:0] sat_sub(
      input logic signed [SUB_W:0] x,
      input logic signed [SUB_W:0] h,
      input int                    w,
      input logic                  sat
   );
      logic signed [SUB_W:0] d;
      logic signed [SUB_W:0] hi;
      logic signed [SUB_W:0] lo;
      d  = x - h;
      hi = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (w - 1));
      if (sat && (d > hi)) begin
         return hi;
      end else if (sat && (d < lo)) begin
         return lo;
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// searching cyclically, as a one-hot vector plus its encoded index.
module rr_arbiter
   import diff_sched_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int CH_W = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [CH_W-1:0] ptr,
   output logic [NCH-1:0]  grant,
   output logic [CH_W-1:0] grant_idx,
   output logic            grant_valid
);

   int c_s;

   // Cyclic first-set search starting at ptr
   always_comb begin
      grant       = {NCH{1'b0}};
      grant_idx   = {CH_W{1'b0}};
      grant_valid = 1'b0;
      c_s         = 0;
      for (int k = 0; k < NCH; k++) begin
         c_s = (int'(ptr) + k) % NCH;
         if (!grant_valid && req[c_s]) begin
            grant_valid = 1'b1;
            grant[c_s]  = 1'b1;
            grant_idx   = CH_W'(c_s);
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/axis_diff_rr_scheduler.sv
// One shared first-difference datapath y[n] = x[n] - x[n-1] time-shared round-robin
// across NCH AXI-Stream lead channels, with per-channel history and a tagged output.
module axis_diff_rr_scheduler
   import diff_sched_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NCH      = 4,
   parameter int SATURATE = 0,
   localparam int CH_W    = ch_width(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       s_axis_tvalid,
   input  logic [NCH*WIDTH-1:0] s_axis_tdata,
   output logic [NCH-1:0]       s_axis_tready,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [WIDTH-1:0]     m_axis_tdata,
   output logic [CH_W-1:0]      m_axis_tuser,
   input  logic [NCH-1:0]       ch_enable,
   input  logic                 clr_hist
);

   if ((NCH < NCH_MIN) || (NCH > NCH_MAX)) begin : g_bad_nch
      $error("axis_diff_rr_scheduler: NCH out of range");
   end

   logic [NCH-1:0]        req_s;
   logic [NCH-1:0]        grant_oh_s;
   logic [CH_W-1:0]       gidx_s;
   logic                  gvalid_s;
   logic                  can_accept_s;
   logic                  accept_s;
   logic [WIDTH-1:0]      x_s;
   logic [WIDTH-1:0]      diff_s;
   logic signed [SUB_W:0] x_ext_s;
   logic signed [SUB_W:0] h_ext_s;
   logic [CH_W-1:0]       ptr_next_s;

   logic [WIDTH-1:0]      hist_r [NCH];
   logic [NCH-1:0]        primed_r;
   logic [CH_W-1:0]       rr_ptr_r;
   logic                  ready_en_r;

   assign req_s = s_axis_tvalid & ch_enable;

   rr_arbiter #(
      .NCH  (NCH),
      .CH_W (CH_W)
   ) u_arb (
      .req         (req_s),
      .ptr         (rr_ptr_r),
      .grant       (grant_oh_s),
      .grant_idx   (gidx_s),
      .grant_valid (gvalid_s)
   );

   // ready_en_r keeps every ready low during the first cycle after reset release
   assign can_accept_s  = ~m_axis_tvalid | m_axis_tready;
   assign accept_s      = gvalid_s & can_accept_s & ~clr_hist & ready_en_r;
   assign s_axis_tready = accept_s ? grant_oh_s : {NCH{1'b0}};

   assign x_s        = s_axis_tdata[gidx_s*WIDTH +: WIDTH];
   assign x_ext_s    = {{(SUB_W+1-WIDTH){x_s[WIDTH-1]}}, x_s};
   assign h_ext_s    = {{(SUB_W+1-WIDTH){hist_r[gidx_s][WIDTH-1]}}, hist_r[gidx_s]};
   assign diff_s     = WIDTH'(sat_sub(x_ext_s, h_ext_s, WIDTH, SATURATE != 0));
   assign ptr_next_s = (gidx_s == CH_W'(NCH-1)) ? {CH_W{1'b0}} : gidx_s + CH_W'(1'b1);

   // History bank, primed flags, round-robin pointer and the single output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            hist_r[i] <= {WIDTH{1'b0}};
         end
         primed_r      <= {NCH{1'b0}};
         rr_ptr_r      <= {CH_W{1'b0}};
         ready_en_r    <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= {WIDTH{1'b0}};
         m_axis_tuser  <= {CH_W{1'b0}};
      end else begin
         ready_en_r <= 1'b1;
         if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (clr_hist) begin
            for (int i = 0; i < NCH; i++) begin
               hist_r[i] <= {WIDTH{1'b0}};
            end
            primed_r <= {NCH{1'b0}};
         end else if (accept_s) begin
            hist_r[gidx_s] <= x_s;
            rr_ptr_r       <= ptr_next_s;
            if (primed_r[gidx_s]) begin
               m_axis_tdata  <= diff_s;
               m_axis_tuser  <= gidx_s;
               m_axis_tvalid <= 1'b1;
            end else begin
               primed_r[gidx_s] <= 1'b1;
            end
         end
      end
   end

endmodule
